// File: rtl/actuator_spi_cmd_rx.sv
// SPI mode-0 slave that turns 16-bit host frames into {op, ch, data} commands
// for the actuator controller, returning a status byte on MISO in the same frame.
module actuator_spi_cmd_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TX_PAD      = 8'h00
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oeb_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [3:0] cmd_op_o,
  output logic [3:0] cmd_ch_o,
  output logic [7:0] cmd_data_o,
  input  logic [7:0] status_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned    FW      = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0]  FLUSH_N = FW'(SYNC_STAGES);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_pipe, csn_pipe, mosi_pipe;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_d, csn_d;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [FW-1:0]          flush_cnt;
  logic                   armed;
  logic [4:0]             bit_cnt;
  logic [15:0]            rx_sr, tx_sr;
  logic                   start, end_good, end_err, good_q;

  assign sck_s  = sck_pipe[SYNC_STAGES-1];
  assign csn_s  = csn_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~csn_s & csn_d;
  assign cs_rise  = csn_s & ~csn_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sck_pipe  <= '0;
      csn_pipe  <= '1;
      mosi_pipe <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck_i};
      csn_pipe  <= {csn_pipe[SYNC_STAGES-1-1:0], spi_csn_i};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
      if (flush_cnt != FLUSH_N) flush_cnt <= flush_cnt + 1'b1;
      // Arm only once the synchronizer holds real pad samples, so its reset
      // value of csn=1 cannot arm against a CS held low through reset.
      if ((flush_cnt == FLUSH_N) && csn_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    end_good  = 1'b0;
    end_err   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == 5'd16) end_good = 1'b1;
          else                  end_err  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bit_cnt        <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      spi_miso_o     <= 1'b0;
      spi_miso_oeb_o <= 1'b1;
      good_q         <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      good_q      <= end_good;
      frame_err_o <= end_err;
      if (start) begin
        bit_cnt        <= '0;
        tx_sr          <= {status_i, TX_PAD};
        spi_miso_o     <= status_i[7];
        spi_miso_oeb_o <= 1'b0;
      end else if (end_good || end_err) begin
        spi_miso_o     <= 1'b0;
        spi_miso_oeb_o <= 1'b1;
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          rx_sr <= {rx_sr[14:0], mosi_s};
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sck_fall) begin
          tx_sr      <= {tx_sr[14:0], 1'b0};
          spi_miso_o <= tx_sr[14];
        end
      end
    end
  end

  // A completed frame may load in the same cycle the held command is accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmd_valid_o <= 1'b0;
      cmd_op_o    <= '0;
      cmd_ch_o    <= '0;
      cmd_data_o  <= '0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (good_q) begin
        if (!cmd_valid_o || cmd_ready_i) begin
          {cmd_op_o, cmd_ch_o, cmd_data_o} <= rx_sr;
          cmd_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (cmd_valid_o && cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
      end
    end
  end

endmodule
